// File: rtl/fetch_unit.sv
// Instruction fetch unit: drives the instruction-memory address, buffers fetched
// words in a small circular queue, and handles redirects and misaligned targets.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        misaligned_err
);

  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef enum logic {FETCH, ERROR} state_t;

  state_t         state;
  logic [31:0]    fetch_pc;
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic [CW-1:0]  count;
  logic [31:0]    pc_mem   [QDEPTH];
  logic [31:0]    data_mem [QDEPTH];
  logic           full;
  logic           push;
  logic           pop;

  assign full       = (count == CW'(QDEPTH));
  assign imem_addr  = fetch_pc;
  // Gated by reset so the request is low while reset is held, not just after it.
  assign imem_req   = !reset && (state == FETCH) && !full && !redirect_valid;
  assign push       = imem_req && imem_ready;
  assign inst_valid = (count != '0);
  assign pop        = inst_valid && inst_ready;
  assign inst_out   = inst_valid ? data_mem[rd_ptr] : '0;
  assign inst_pc    = inst_valid ? pc_mem[rd_ptr]   : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= FETCH;
      fetch_pc       <= RESET_PC;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      misaligned_err <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      if (redirect_pc[1:0] != 2'b00) begin
        state          <= ERROR;
        misaligned_err <= 1'b1;
      end else begin
        state          <= FETCH;
        misaligned_err <= 1'b0;
      end
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= fetch_pc;
      data_mem[wr_ptr] <= imem_rdata;
    end
  end

endmodule
